// File: rtl/instruction_fetch_stage_pkg.sv
// Shared definitions for the fetch stage: default field widths and the
// opcodes the IF stage needs to recognise (NOP for bubbles, JMP for the
// early-jump predecode).
package instruction_fetch_stage_pkg;

  localparam int DEF_ADDR_W   = 10;
  localparam int DEF_INSTR_W  = 16;
  localparam int DEF_OPCODE_W = 6;

  localparam logic [DEF_OPCODE_W-1:0] OPC_NOP = 6'h00;
  localparam logic [DEF_OPCODE_W-1:0] OPC_JMP = 6'h20;

endpackage

// File: rtl/instruction_fetch_stage_if.sv
// Bus between the IF stage and its environment (ROM, hazard unit, later
// stages, decode).
// Handshake: there is no valid/ready backpressure on this bus. oValid
// qualifies oInstruction/oPC/oPCPlus1 every cycle; iStall is the only
// flow control and freezes the stage while high. iTarget is meaningful only
// in a cycle where iRedirect is high.
interface instruction_fetch_stage_if #(
  parameter int ADDR_W  = instruction_fetch_stage_pkg::DEF_ADDR_W,
  parameter int INSTR_W = instruction_fetch_stage_pkg::DEF_INSTR_W
);
  logic [ADDR_W-1:0]  oAddress;
  logic [INSTR_W-1:0] iInstruction;
  logic               iStall;
  logic               iRedirect;
  logic [ADDR_W-1:0]  iTarget;
  logic               iHalt;
  logic [INSTR_W-1:0] oInstruction;
  logic [ADDR_W-1:0]  oPC;
  logic [ADDR_W-1:0]  oPCPlus1;
  logic               oValid;

  // The fetch stage itself
  modport master (
    output oAddress, oInstruction, oPC, oPCPlus1, oValid,
    input  iInstruction, iStall, iRedirect, iTarget, iHalt
  );

  // ROM, hazard unit, downstream stages
  modport slave (
    input  oAddress, oInstruction, oPC, oPCPlus1, oValid,
    output iInstruction, iStall, iRedirect, iTarget, iHalt
  );
endinterface

// File: rtl/instruction_fetch_stage_if_id_register.sv
// Generic pipeline register holding instruction, PC and valid.
// flush loads a bubble (NOP word, valid=0, PC kept), load captures a new
// instruction, neither holds. flush wins over load.
module instruction_fetch_stage_if_id_register #(
  parameter int                  ADDR_W   = 10,
  parameter int                  INSTR_W  = 16,
  parameter logic [INSTR_W-1:0]  NOP_WORD = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               flush_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [ADDR_W-1:0]  pc_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  pc_o,
  output logic [ADDR_W-1:0]  pc_plus1_o,
  output logic               valid_o
);

  logic [INSTR_W-1:0] instr_q;
  logic [ADDR_W-1:0]  pc_q;
  logic               valid_q;

  // Flush to bubble, load new word, or hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= NOP_WORD;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      instr_q <= NOP_WORD;
      valid_q <= 1'b0;
    end else if (load_i) begin
      instr_q <= instr_i;
      pc_q    <= pc_i;
      valid_q <= 1'b1;
    end
  end

  assign instr_o    = instr_q;
  assign pc_o       = pc_q;
  assign pc_plus1_o = pc_q + ADDR_W'(1);
  assign valid_o    = valid_q;

endmodule

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: owns the PC, addresses the combinational ROM and
// captures the returned word into the IF/ID register. Handles stall,
// redirect/flush, halt and an optional in-IF JMP predecode.
module instruction_fetch_stage
  import instruction_fetch_stage_pkg::*;
#(
  parameter int                ADDR_W     = DEF_ADDR_W,
  parameter int                INSTR_W    = DEF_INSTR_W,
  parameter int                OPCODE_W   = DEF_OPCODE_W,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter bit                EARLY_JUMP = 1'b0
) (
  input  logic                        Clock,
  input  logic                        Reset,
  instruction_fetch_stage_if.master   bus,
  output logic [1:0]                  oState
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [INSTR_W-1:0] NOP_WORD =
    INSTR_W'(OPCODE_W'(OPC_NOP)) << (INSTR_W - OPCODE_W);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              load, flush;
  logic              is_jmp;

  assign is_jmp = (bus.iInstruction[INSTR_W-1 -: OPCODE_W] == OPCODE_W'(OPC_JMP));

  // Next PC, next state and IF/ID control, redirect first, then halt, stall, fetch
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    load    = 1'b0;
    flush   = 1'b0;
    case (state_q)
      ST_BOOT: begin
        flush   = 1'b1;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bus.iRedirect) begin
          pc_d  = bus.iTarget;
          flush = 1'b1;
        end else if (bus.iHalt) begin
          flush   = 1'b1;
          state_d = ST_HALT;
        end else if (bus.iStall) begin
          load = 1'b0;
        end else if (EARLY_JUMP && is_jmp) begin
          load = 1'b1;
          pc_d = bus.iInstruction[ADDR_W-1:0];
        end else begin
          load = 1'b1;
          pc_d = pc_q + ADDR_W'(1);
        end
      end
      ST_HALT: begin
        flush = 1'b1;
        if (bus.iRedirect) begin
          pc_d    = bus.iTarget;
          state_d = ST_RUN;
        end
      end
      default: begin
        flush   = 1'b1;
        state_d = ST_BOOT;
      end
    endcase
  end

  // State and PC registers
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  instruction_fetch_stage_if_id_register #(
    .ADDR_W   (ADDR_W),
    .INSTR_W  (INSTR_W),
    .NOP_WORD (NOP_WORD)
  ) u_if_id (
    .clk        (Clock),
    .rst_n      (Reset),
    .load_i     (load),
    .flush_i    (flush),
    .instr_i    (bus.iInstruction),
    .pc_i       (pc_q),
    .instr_o    (bus.oInstruction),
    .pc_o       (bus.oPC),
    .pc_plus1_o (bus.oPCPlus1),
    .valid_o    (bus.oValid)
  );

  assign bus.oAddress = pc_q;
  assign oState       = state_q;

endmodule

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
- IF stage of the pipelined core: owns the program counter, drives the 10-bit address into the combinational instruction ROM and captures the returned 16-bit word into the IF/ID pipeline register.
- Handles stall (hazard unit), redirect/flush (taken JMP/branch resolved downstream) and halt.
- The optional EARLY_JUMP path predecodes JMP in IF to save redirect cycles.
- Output feeds the decode stage.

Parameters:
- ADDR_W, 10, PC / ROM address width.
- INSTR_W, 16, instruction width.
- OPCODE_W, 6, opcode field = instruction[INSTR_W-1 -: OPCODE_W]; operand = low ADDR_W bits.
- RESET_PC, 0, PC value loaded on reset.
- EARLY_JUMP, 0, 1 = redirect PC on a fetched `JMP` in IF.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low reset.
- oAddress  out  ADDR_W  to ROM iAddress; equals PC register (combinational).
- iInstruction  in  INSTR_W  from ROM oInstruction, same cycle.
- iStall  in  1  hold PC and IF/ID contents.
- iRedirect  in  1  taken control transfer from a later stage; flush.
- iTarget  in  ADDR_W  new PC when iRedirect=1.
- iHalt  in  1  enter HALT.
- oInstruction  out  INSTR_W  IF/ID instruction register.
- oPC  out  ADDR_W  address of the word in oInstruction.
- oPCPlus1  out  ADDR_W  oPC+1 modulo 2^ADDR_W.
- oValid  out  1  IF/ID holds a real instruction (0 = bubble).

Behaviour:
- Reset (async, Reset=0):
  - PC=RESET_PC, oInstruction={`NOP,10'd0}, oPC=0, oPCPlus1=1, oValid=0, state=BOOT.
  - Reset asserted mid-operation discards all state immediately.
- State BOOT:
  - Lasts exactly one cycle after reset release.
  - IF/ID loads a bubble (NOP, oValid=0); PC unchanged; -> RUN.
  - Guarantees the ROM settles before the first capture.
- State RUN, per rising edge, highest priority first:
  1. iRedirect: PC<=iTarget; IF/ID<=NOP, oValid<=0; overrides iStall and iHalt in the same cycle.
  2. iHalt: IF/ID<=NOP, oValid<=0; PC held; -> HALT.
  3. iStall: PC, oInstruction, oPC, oPCPlus1 and oValid all held.
  4. EARLY_JUMP=1 and iInstruction opcode==`JMP: IF/ID<=word, oValid<=1, oPC<=PC; PC<=operand[ADDR_W-1:0].
  5. Otherwise: IF/ID<=iInstruction, oPC<=PC, oValid<=1; PC<=PC+1.
- State HALT:
  - PC held; IF/ID forced to NOP, oValid=0.
  - iRedirect -> PC<=iTarget, -> RUN (first real fetch is the next cycle). iStall ignored.
- Width and latency:
  - PC arithmetic is modulo 2^ADDR_W: 1023+1 wraps to 0. oPCPlus1 wraps the same way.
  - Latency: the word at address A appears on oInstruction one edge after oAddress=A.
  - Sustained throughput: 1 instruction per cycle when not stalled.
- Other rules:
  - A fetched `NOP` is captured with oValid=1; it is a real instruction, not a bubble.
  - Redirect with iTarget==PC is legal: refetch, with one bubble.
  - iTarget is sampled only when iRedirect=1.

Decomposition:
- Opcode macros (`NOP, `JMP, field widths) come from the shared definitions include file; no local opcode constants.
- State encoding (BOOT/RUN/HALT) is local to the module.
- One natural sub-module: if_id_register. It holds instruction/PC/valid with load, hold and flush controls; it is reused by later pipeline registers.

Test Plan:
- Reset release with a ROM holding words at 0..3 -> one bubble cycle (oValid=0), then oPC=0,1,2,3 on consecutive cycles with matching oInstruction and oValid=1.
- iStall=1 for 3 cycles while oPC=5 -> oAddress stays 6 and oPC stays 5 throughout; normal sequence resumes at oPC=6 after release.
- iRedirect=1, iTarget=14 while iStall=1 at PC=18 -> next cycle oValid=0 with NOP; following cycle oPC=14.
- EARLY_JUMP=1, `JMP 10'd1000 fetched at address 18 -> oPC=18 valid, next oAddress=1000, no bubble. With EARLY_JUMP=0 -> oAddress=19.
- PC=1023 free-running -> oAddress wraps to 0 and oPCPlus1=0 when oPC=1023.
- iHalt at PC=9 -> continuous NOP bubbles with PC=9 held. Then iRedirect, iTarget=2 -> RUN, oPC=2 valid two edges later. Reset asserted mid-HALT -> all outputs return to reset values immediately.
